// File: rtl/islip_pointer_update_if.sv
// Handshake/bus bundle for the iSLIP round-robin pointer register.
// master drives grant/load requests; slave returns pointer state and flags.
interface islip_pointer_update_if #(
    parameter int N  = 32,
    parameter int W  = $clog2(N),
    parameter int CW = 16
);
    logic          grant_vld;
    logic [N-1:0]  grant;
    logic          accept;
    logic          iter_first;
    logic          load_vld;
    logic [N-1:0]  load_code;
    logic [N-1:0]  point;
    logic [W-1:0]  point_idx;
    logic          upd_pulse;
    logic          load_done;
    logic          err_grant;
    logic          err_code;
    logic          collide;
    logic [CW-1:0] upd_cnt;

    modport master (
        output grant_vld, grant, accept, iter_first, load_vld, load_code,
        input  point, point_idx, upd_pulse, load_done,
        input  err_grant, err_code, collide, upd_cnt
    );

    modport slave (
        input  grant_vld, grant, accept, iter_first, load_vld, load_code,
        output point, point_idx, upd_pulse, load_done,
        output err_grant, err_code, collide, upd_cnt
    );
endinterface

// File: rtl/islip_pointer_update.sv
// Registered one-hot round-robin pointer for one iSLIP arbiter,
// advanced by accepted first-iteration grants or loaded from a mask code.
module islip_pointer_update #(
    parameter int N  = 32,
    parameter int W  = $clog2(N),
    parameter int CW = 16
) (
    input logic clk,
    input logic rst,
    islip_pointer_update_if.slave bus
);
    logic          qual;
    logic          grant_ok;
    logic          code_ok;
    logic [W-1:0]  grant_idx;
    logic [W-1:0]  next_idx;
    logic [W-1:0]  code_pop;
    logic [N-1:0]  rot_point;
    logic [N-1:0]  dec_point;

    assign qual = bus.grant_vld & bus.accept & bus.iter_first;

    assign grant_ok = (bus.grant != '0)
                    && ((bus.grant & (bus.grant - N'(1))) == '0);

    // Legal code is 2^p-1 with the top bit clear.
    assign code_ok = ((bus.load_code & (bus.load_code + N'(1))) == '0)
                   && !bus.load_code[N-1];

    assign rot_point = {bus.grant[N-2:0], bus.grant[N-1]};

    assign dec_point = {bus.load_code[N-2:0] & ~bus.load_code[N-1:1],
                        ~bus.load_code[0]};

    always_comb begin
        grant_idx = '0;
        code_pop  = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.grant[i])
                grant_idx = W'(i);
            if (bus.load_code[i])
                code_pop = code_pop + W'(1);
        end
    end

    assign next_idx = (grant_idx == W'(N-1)) ? '0 : grant_idx + W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.point     <= N'(1);
            bus.point_idx <= '0;
            bus.upd_pulse <= 1'b0;
            bus.load_done <= 1'b0;
            bus.collide   <= 1'b0;
            bus.err_grant <= 1'b0;
            bus.err_code  <= 1'b0;
            bus.upd_cnt   <= '0;
        end else begin
            bus.upd_pulse <= 1'b0;
            bus.load_done <= 1'b0;
            bus.collide   <= bus.load_vld & qual;
            // Load wins over a coincident grant; the grant is dropped.
            if (bus.load_vld) begin
                if (code_ok) begin
                    bus.point     <= dec_point;
                    bus.point_idx <= code_pop;
                    bus.load_done <= 1'b1;
                end else begin
                    bus.err_code  <= 1'b1;
                end
            end else if (qual) begin
                if (grant_ok) begin
                    bus.point     <= rot_point;
                    bus.point_idx <= next_idx;
                    bus.upd_pulse <= 1'b1;
                    if (bus.upd_cnt != '1)
                        bus.upd_cnt <= bus.upd_cnt + CW'(1);
                end else begin
                    bus.err_grant <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_islip_pointer_update.sv
// Directed bench for islip_pointer_update with a per-cycle reference model.
// Model tracks the pointer as an integer port number.
module tb_islip_pointer_update;
    localparam int N  = 8;
    localparam int W  = 3;
    localparam int CW = 16;

    logic clk = 0;
    logic rst = 0;
    int checks = 0;
    int failures = 0;

    islip_pointer_update_if #(.N(N), .W(W), .CW(CW)) bus ();

    islip_pointer_update #(.N(N), .W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int m_p = 0;
    int m_cnt = 0;
    bit m_upd = 0, m_ld = 0, m_col = 0, m_eg = 0, m_ec = 0;
    bit m_valid = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit q;
        int p;
        q = bus.grant_vld && bus.accept && bus.iter_first;
        if (rst) begin
            m_p = 0; m_cnt = 0;
            m_upd = 0; m_ld = 0; m_col = 0; m_eg = 0; m_ec = 0;
            m_valid = 1;
        end else begin
            m_upd = 0; m_ld = 0;
            m_col = bus.load_vld && q;
            if (bus.load_vld) begin
                p = $countones(bus.load_code);
                if (p <= N-1 && int'(bus.load_code) == (1 << p) - 1) begin
                    m_p = p; m_ld = 1;
                end else begin
                    m_ec = 1;
                end
            end else if (q) begin
                if ($countones(bus.grant) == 1) begin
                    for (int i = 0; i < N; i++)
                        if (bus.grant[i]) p = i;
                    m_p = (p + 1) % N;
                    m_upd = 1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end else begin
                    m_eg = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("point", bus.point, longint'(1) << m_p);
            chk("point_idx", bus.point_idx, m_p);
            chk("upd_pulse", bus.upd_pulse, m_upd);
            chk("load_done", bus.load_done, m_ld);
            chk("collide", bus.collide, m_col);
            chk("err_grant", bus.err_grant, m_eg);
            chk("err_code", bus.err_code, m_ec);
            chk("upd_cnt", bus.upd_cnt, m_cnt);
        end
    end

    task automatic idle_in();
        bus.grant_vld = 0; bus.grant = '0; bus.accept = 0;
        bus.iter_first = 0; bus.load_vld = 0; bus.load_code = '0;
        rst = 0;
    endtask

    task automatic step(input bit r, input bit gv, input logic [N-1:0] g,
                        input bit acc, input bit itf,
                        input bit lv, input logic [N-1:0] lc);
        rst = r;
        bus.grant_vld = gv; bus.grant = g; bus.accept = acc;
        bus.iter_first = itf; bus.load_vld = lv; bus.load_code = lc;
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic grant_q(input logic [N-1:0] g);
        step(0, 1, g, 1, 1, 0, '0);
    endtask

    task automatic load(input logic [N-1:0] c);
        step(0, 0, '0, 0, 0, 1, c);
    endtask

    initial begin
        idle_in();
        @(negedge clk);
        step(1, 0, '0, 0, 0, 0, '0);
        step(1, 0, '0, 0, 0, 0, '0);
        chk("rst_point", bus.point, 8'h01);
        chk("rst_idx", bus.point_idx, 0);
        chk("rst_cnt", bus.upd_cnt, 0);
        chk("rst_flags", {bus.upd_pulse, bus.load_done, bus.collide,
                          bus.err_grant, bus.err_code}, 0);

        grant_q(8'h04);
        chk("g04_point", bus.point, 8'h08);
        chk("g04_idx", bus.point_idx, 3);
        chk("g04_pulse", bus.upd_pulse, 1);
        chk("g04_cnt", bus.upd_cnt, 1);
        step(0, 0, '0, 0, 0, 0, '0);
        chk("g04_pulse_end", bus.upd_pulse, 0);

        grant_q(8'h80);
        chk("wrap_point", bus.point, 8'h01);
        chk("wrap_idx", bus.point_idx, 0);

        step(0, 1, 8'h10, 0, 1, 0, '0);
        chk("noacc_point", bus.point, 8'h01);
        chk("noacc_pulse", bus.upd_pulse, 0);
        step(0, 1, 8'h10, 1, 0, 0, '0);
        chk("noiter_point", bus.point, 8'h01);
        chk("noiter_cnt", bus.upd_cnt, 2);

        load(8'h1F);
        chk("ld1f_point", bus.point, 8'h20);
        chk("ld1f_idx", bus.point_idx, 5);
        chk("ld1f_done", bus.load_done, 1);
        load(8'h00);
        chk("ld00_point", bus.point, 8'h01);

        load(8'h0B);
        chk("ld0b_point", bus.point, 8'h01);
        chk("ld0b_err", bus.err_code, 1);
        chk("ld0b_done", bus.load_done, 0);
        step(0, 0, '0, 0, 0, 0, '0);
        chk("errcode_sticky", bus.err_code, 1);

        step(1, 0, '0, 0, 0, 0, '0);
        chk("rst_errcode", bus.err_code, 0);
        load(8'h80);
        chk("ld80_err", bus.err_code, 1);
        chk("ld80_point", bus.point, 8'h01);

        step(0, 1, 8'h01, 1, 1, 1, 8'h07);
        chk("col_point", bus.point, 8'h08);
        chk("col_collide", bus.collide, 1);
        chk("col_pulse", bus.upd_pulse, 0);
        step(0, 0, '0, 0, 0, 0, '0);
        chk("col_end", bus.collide, 0);

        grant_q(8'h06);
        chk("bad_err", bus.err_grant, 1);
        chk("bad_point", bus.point, 8'h08);

        for (int i = 0; i < 70000; i++)
            grant_q(8'h01 << (i % N));
        chk("sat_cnt", bus.upd_cnt, 16'hFFFF);

        step(1, 1, 8'h02, 1, 1, 0, '0);
        chk("mid_rst_point", bus.point, 8'h01);
        chk("mid_rst_cnt", bus.upd_cnt, 0);
        chk("mid_rst_err", {bus.err_grant, bus.err_code, bus.upd_pulse}, 0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
